program_memory: RTL and testbench
=================================

PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 The block SHALL have exactly one clock and one reset: i_Clk input 1 is the single clock, all state changes on its rising edge; i_Reset_n input 1 is the reset, asynchronous, active-low.
REQ-002 Port: i_Addressinstruction_Bus  input  9  instruction address from the jump/PC unit.
REQ-003 Port: o_Instruction  output  16  fetched instruction word.
REQ-004 Port: o_Instr_Valid  output  1  o_Instruction is valid for the current address.
REQ-005 Port: o_Hold_Core  output  1  core stall request; high whenever the block is not in RUN.
REQ-006 Port: i_Load_Start  input  1  one-cycle pulse that begins a program download.
REQ-007 Port: i_Load_Byte  input  8  download byte stream from the UART receiver.
REQ-008 Port: i_Load_Valid  input  1  i_Load_Byte is valid.
REQ-009 Port: o_Load_Ready  output  1  the block accepts a byte this cycle; a transfer occurs when i_Load_Valid and o_Load_Ready are both high.
REQ-010 Port: o_Load_Done  output  1  one-cycle pulse when the download completes successfully.
REQ-011 Port: o_Load_Error  output  1  sticky flag; set on an illegal length and cleared by the next i_Load_Start or by reset.

Function
REQ-012 The storage SHALL be 512 words x 16 bits, with word address equal to i_Addressinstruction_Bus.
REQ-013 The FSM SHALL have the states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO and RUN.
REQ-014 An i_Load_Start pulse in IDLE or RUN SHALL move the FSM to LEN_HI, clear o_Load_Error, the word pointer and the loaded-word count, and drop o_Instr_Valid.
REQ-015 An i_Load_Start pulse in LEN_HI, LEN_LO, DATA_HI or DATA_LO SHALL be ignored.
REQ-016 o_Load_Ready SHALL be high only in LEN_HI, LEN_LO, DATA_HI and DATA_LO.
REQ-017 Each accepted byte SHALL advance the FSM: LEN_HI to LEN_LO, LEN_LO to DATA_HI, DATA_HI to DATA_LO, DATA_LO to DATA_HI; a cycle without a transfer SHALL hold the state.
REQ-018 The length field N SHALL be 16 bits, big-endian, assembled from the LEN_HI and LEN_LO bytes.
REQ-019 If N = 0 or N > 512, the LEN_LO transfer SHALL set o_Load_Error and move the FSM to IDLE.
REQ-020 Data words SHALL be big-endian (high byte first).
REQ-021 On the DATA_LO transfer the block SHALL write mem[ptr] = {hi, lo} and increment ptr.
REQ-022 When ptr reaches N, the same DATA_LO transfer SHALL set the loaded-word count to N, pulse o_Load_Done for one cycle, and move the FSM to RUN.
REQ-023 ptr SHALL be 10 bits wide so that the value 512 is representable, and SHALL never wrap.
REQ-024 In RUN, fetch latency SHALL be one cycle: o_Instruction on cycle t+1 = mem[address presented on cycle t].
REQ-025 In RUN, an address >= the loaded-word count SHALL return NOP (16'h0000).
REQ-026 o_Instr_Valid SHALL rise one cycle after entering RUN and stay high while in RUN.
REQ-027 Outside RUN, o_Instr_Valid SHALL be low and o_Instruction SHALL be held at 16'h0000.
REQ-028 o_Hold_Core SHALL be a registered decode of the state: low only in RUN.

Reset
REQ-029 When i_Reset_n is low (asynchronous) the block SHALL force: FSM = IDLE, ptr = 0, loaded-word count = 0, o_Instruction = 0, o_Instr_Valid = 0, o_Hold_Core = 1, o_Load_Ready = 0, o_Load_Done = 0, o_Load_Error = 0.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Because a reset mid-download zeroes the loaded-word count, all fetches SHALL return NOP until a new download completes.

Structure
REQ-032 A shared package SHALL hold: the state enum, ADDR_W = 9, INSTR_W = 16, DEPTH = 512, NOP = 16'h0000.
REQ-033 Sub-module prog_ram SHALL contain only the storage: one synchronous write port and one synchronous read port, with no reset.
REQ-034 The FSM, pointer, length and bounds check SHALL reside in program_memory.

Verification
REQ-035 Reset then i_Load_Start, stream 00 03 12 34 AB CD 00 01 -> o_Load_Done pulses exactly once; o_Hold_Core falls; addresses 0,1,2,3 give 1234, ABCD, 0001, 0000 one cycle later.
REQ-036 Length 00 00, and separately length 02 01 -> o_Load_Error = 1; FSM in IDLE; o_Hold_Core = 1; no further bytes accepted.
REQ-037 Full load with N = 512 and data = index -> address 511 returns 01FF; ptr does not wrap; o_Load_Done pulses once.
REQ-038 i_Load_Valid toggled randomly and i_Load_Start pulsed mid-data -> the extra start is ignored and the image is loaded correctly.
REQ-039 i_Reset_n asserted after 2 data words -> all outputs take their reset values immediately; any fetch after a subsequent RUN-less period returns 0000; reload with N = 1, word BEEF -> address 0 returns BEEF.
REQ-040 In RUN, an i_Load_Start pulse -> o_Instr_Valid drops on the next cycle, o_Hold_Core rises, and a new image replaces the old one.

Source files
------------

// File: rtl/program_memory_pkg.sv
// ============================================================================
// Module   : program_memory_pkg
// Brief    : Shared types and sizing for the program memory and its RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package program_memory_pkg;

    localparam int ADDR_W  = 9;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 512;
    localparam int PTR_W   = 10;

    localparam logic [INSTR_W-1:0] NOP     = 16'h0000;
    localparam logic [15:0]        MAX_LEN = 16'(DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        RUN     = 3'd5
    } pm_state_e;

    function automatic logic is_loading(input pm_state_e s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) || (s == DATA_LO);
    endfunction

endpackage

`default_nettype wire

// File: rtl/program_memory_ram.sv
// ============================================================================
// Module   : prog_ram
// Brief    : 512x16 storage, one synchronous write and one synchronous read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_ram
    import program_memory_pkg::*;
(
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

`default_nettype wire

// File: rtl/program_memory.sv
// ============================================================================
// Module   : program_memory
// Brief    : Instruction store with a byte-stream download FSM (length + words).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_memory
    import program_memory_pkg::*;
(
    input  logic               i_Clk,
    input  logic               i_Reset_n,
    input  logic [ADDR_W-1:0]  i_Addressinstruction_Bus,
    output logic [INSTR_W-1:0] o_Instruction,
    output logic               o_Instr_Valid,
    output logic               o_Hold_Core,
    input  logic               i_Load_Start,
    input  logic [7:0]         i_Load_Byte,
    input  logic               i_Load_Valid,
    output logic               o_Load_Ready,
    output logic               o_Load_Done,
    output logic               o_Load_Error
);

    pm_state_e          state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   len_q, len_d;
    logic [7:0]         len_hi_q, len_hi_d;
    logic [7:0]         data_hi_q, data_hi_d;
    logic               err_d, done_d, valid_d, fetch_d, ready_d, hold_d;
    logic               fetch_q;
    logic               w_xfer;
    logic               w_we;
    logic [15:0]        w_len;
    logic [PTR_W-1:0]   w_ptr_inc;
    logic [INSTR_W-1:0] w_rdata;

    assign w_xfer    = i_Load_Valid && o_Load_Ready;
    assign w_len     = {len_hi_q, i_Load_Byte};
    assign w_ptr_inc = ptr_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        len_d     = len_q;
        len_hi_d  = len_hi_q;
        data_hi_d = data_hi_q;
        err_d     = o_Load_Error;
        done_d    = 1'b0;
        w_we      = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                if (i_Load_Start) begin
                    state_d = LEN_HI;
                    err_d   = 1'b0;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end
            LEN_HI: if (w_xfer) begin
                len_hi_d = i_Load_Byte;
                state_d  = LEN_LO;
            end
            LEN_LO: if (w_xfer) begin
                if ((w_len == 16'd0) || (w_len > MAX_LEN)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    len_d   = w_len[PTR_W-1:0];
                    state_d = DATA_HI;
                end
            end
            DATA_HI: if (w_xfer) begin
                data_hi_d = i_Load_Byte;
                state_d   = DATA_LO;
            end
            DATA_LO: if (w_xfer) begin
                w_we  = 1'b1;
                ptr_d = w_ptr_inc;
                // Stopping exactly at N keeps ptr from ever wrapping past 512.
                if (w_ptr_inc == len_q) begin
                    count_d = len_q;
                    done_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = DATA_HI;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registers line up with state_q.
        ready_d = is_loading(state_d);
        hold_d  = (state_d != RUN);
        valid_d = (state_q == RUN) && (state_d == RUN);
        fetch_d = valid_d && ({1'b0, i_Addressinstruction_Bus} < count_q);
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            count_q       <= '0;
            len_q         <= '0;
            len_hi_q      <= '0;
            data_hi_q     <= '0;
            fetch_q       <= 1'b0;
            o_Instr_Valid <= 1'b0;
            o_Hold_Core   <= 1'b1;
            o_Load_Ready  <= 1'b0;
            o_Load_Done   <= 1'b0;
            o_Load_Error  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            count_q       <= count_d;
            len_q         <= len_d;
            len_hi_q      <= len_hi_d;
            data_hi_q     <= data_hi_d;
            fetch_q       <= fetch_d;
            o_Instr_Valid <= valid_d;
            o_Hold_Core   <= hold_d;
            o_Load_Ready  <= ready_d;
            o_Load_Done   <= done_d;
            o_Load_Error  <= err_d;
        end
    end

    prog_ram u_ram (
        .clk_i   (i_Clk),
        .we_i    (w_we),
        .waddr_i (ptr_q[ADDR_W-1:0]),
        .wdata_i ({data_hi_q, i_Load_Byte}),
        .raddr_i (i_Addressinstruction_Bus),
        .rdata_o (w_rdata)
    );

    assign o_Instruction = fetch_q ? w_rdata : NOP;

endmodule

`default_nettype wire

// File: tb/tb_program_memory.sv
// ============================================================================
// Module   : tb_program_memory
// Brief    : Self-checking bench for program_memory against an array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_memory;

    logic        i_Clk = 1'b0;
    logic        i_Reset_n;
    logic [8:0]  i_Addressinstruction_Bus;
    logic [15:0] o_Instruction;
    logic        o_Instr_Valid;
    logic        o_Hold_Core;
    logic        i_Load_Start;
    logic [7:0]  i_Load_Byte;
    logic        i_Load_Valid;
    logic        o_Load_Ready;
    logic        o_Load_Done;
    logic        o_Load_Error;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] model_mem [512];
    int          model_count = 0;
    logic [15:0] img [512];

    always #5 i_Clk = ~i_Clk;

    program_memory dut (
        .i_Clk                    (i_Clk),
        .i_Reset_n                (i_Reset_n),
        .i_Addressinstruction_Bus (i_Addressinstruction_Bus),
        .o_Instruction            (o_Instruction),
        .o_Instr_Valid            (o_Instr_Valid),
        .o_Hold_Core              (o_Hold_Core),
        .i_Load_Start             (i_Load_Start),
        .i_Load_Byte              (i_Load_Byte),
        .i_Load_Valid             (i_Load_Valid),
        .o_Load_Ready             (o_Load_Ready),
        .o_Load_Done              (o_Load_Done),
        .o_Load_Error             (o_Load_Error)
    );

    task automatic pulse_start();
        i_Load_Start = 1'b1;
        @(negedge i_Clk);
        i_Load_Start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic expect_done, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                i_Load_Byte = 8'($urandom);
                @(negedge i_Clk);
            end
        end
        i_Load_Byte  = b;
        i_Load_Valid = 1'b1;
        n = 0;
        while (o_Load_Ready !== 1'b1 && n < 16) begin
            @(negedge i_Clk);
            n++;
        end
        n_cmp++;
        if (o_Load_Ready !== 1'b1) begin
            n_err++;
            $display("FAIL load_ready: got %b need 1 (byte %h)", o_Load_Ready, b);
        end
        @(negedge i_Clk);
        i_Load_Valid = 1'b0;
        n_cmp++;
        if (o_Load_Done !== expect_done) begin
            n_err++;
            $display("FAIL load_done: got %b need %b (byte %h)", o_Load_Done, expect_done, b);
        end
    endtask

    task automatic load_image(input int n, input bit do_start, input bit gaps, input bit mid_start);
        logic [15:0] len;
        len = 16'(n);
        if (do_start) begin
            pulse_start();
            n_cmp++;
            if ({o_Load_Ready, o_Load_Error, o_Hold_Core, o_Instr_Valid} !== 4'b1010) begin
                n_err++;
                $display("FAIL start_outputs: got rdy/err/hold/vld=%b need 1010",
                         {o_Load_Ready, o_Load_Error, o_Hold_Core, o_Instr_Valid});
            end
        end
        push_byte(len[15:8], 1'b0, gaps);
        push_byte(len[7:0], 1'b0, gaps);
        for (int i = 0; i < n; i++) begin
            if (mid_start && i == n / 2) pulse_start();
            push_byte(img[i][15:8], 1'b0, gaps);
            model_mem[i] = img[i];
            push_byte(img[i][7:0], (i == n - 1), gaps);
        end
        model_count = n;
        n_cmp++;
        if (o_Hold_Core !== 1'b0 || o_Instr_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL run_entry: got hold=%b vld=%b need 0 0", o_Hold_Core, o_Instr_Valid);
        end
        @(negedge i_Clk);
        n_cmp++;
        if (o_Instr_Valid !== 1'b1 || o_Load_Done !== 1'b0) begin
            n_err++;
            $display("FAIL run_valid: got vld=%b done=%b need 1 0", o_Instr_Valid, o_Load_Done);
        end
    endtask

    task automatic fetch_one(input logic [8:0] a);
        logic [15:0] exp;
        i_Addressinstruction_Bus = a;
        @(negedge i_Clk);
        exp = (int'(a) < model_count) ? model_mem[a] : 16'h0000;
        n_cmp++;
        if (o_Instruction !== exp || o_Instr_Valid !== 1'b1) begin
            n_err++;
            $display("FAIL fetch: addr %0d got %h vld=%b need %h vld=1", a, o_Instruction, o_Instr_Valid, exp);
        end
    endtask

    task automatic check_fetch(input int k);
        logic [8:0] a;
        if (model_count < 512) fetch_one(9'(model_count));
        fetch_one(9'(model_count - 1));
        for (int i = 0; i < k; i++) begin
            if ($urandom_range(0, 1) == 1) a = 9'($urandom_range(0, model_count - 1));
            else                          a = 9'($urandom);
            fetch_one(a);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({o_Instruction, o_Instr_Valid, o_Hold_Core, o_Load_Ready, o_Load_Done, o_Load_Error}
                !== {16'h0000, 5'b01000}) begin
            n_err++;
            $display("FAIL reset_values: got instr=%h vld/hold/rdy/done/err=%b need 0000 01000",
                     o_Instruction, {o_Instr_Valid, o_Hold_Core, o_Load_Ready, o_Load_Done, o_Load_Error});
        end
        i_Reset_n = 1'b1;
        repeat (3) @(negedge i_Clk);
        n_cmp++;
        if (o_Hold_Core !== 1'b1 || o_Load_Ready !== 1'b0 || o_Instr_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got hold=%b rdy=%b vld=%b need 1 0 0",
                     o_Hold_Core, o_Load_Ready, o_Instr_Valid);
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp_tab [4];
        exp_tab = '{16'h1234, 16'hABCD, 16'h0001, 16'h0000};
        img[0] = 16'h1234;
        img[1] = 16'hABCD;
        img[2] = 16'h0001;
        load_image(3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            i_Addressinstruction_Bus = 9'(i);
            @(negedge i_Clk);
            n_cmp++;
            if (o_Instruction !== exp_tab[i]) begin
                n_err++;
                $display("FAIL basic_fetch: addr %0d got %h need %h", i, o_Instruction, exp_tab[i]);
            end
        end
        check_fetch(10);
    endtask

    task automatic test_bad_length(input logic [15:0] len);
        pulse_start();
        n_cmp++;
        if (o_Load_Error !== 1'b0 || o_Load_Ready !== 1'b1) begin
            n_err++;
            $display("FAIL bad_len_start: got err=%b rdy=%b need 0 1", o_Load_Error, o_Load_Ready);
        end
        push_byte(len[15:8], 1'b0, 1'b0);
        push_byte(len[7:0], 1'b0, 1'b0);
        model_count = 0;
        n_cmp++;
        if (o_Load_Error !== 1'b1 || o_Load_Ready !== 1'b0 || o_Hold_Core !== 1'b1) begin
            n_err++;
            $display("FAIL bad_len %h: got err=%b rdy=%b hold=%b need 1 0 1",
                     len, o_Load_Error, o_Load_Ready, o_Hold_Core);
        end
        i_Load_Valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_Addressinstruction_Bus = 9'($urandom);
            @(negedge i_Clk);
            n_cmp++;
            if (o_Load_Ready !== 1'b0 || o_Load_Error !== 1'b1 || o_Instruction !== 16'h0000) begin
                n_err++;
                $display("FAIL bad_len_hold: got rdy=%b err=%b instr=%h need 0 1 0000",
                         o_Load_Ready, o_Load_Error, o_Instruction);
            end
        end
        i_Load_Valid = 1'b0;
    endtask

    task automatic test_full();
        for (int i = 0; i < 512; i++) img[i] = 16'(i);
        load_image(512, 1'b1, 1'b0, 1'b0);
        fetch_one(9'd511);
        n_cmp++;
        if (o_Instruction !== 16'h01FF) begin
            n_err++;
            $display("FAIL full_last: got %h need 01ff", o_Instruction);
        end
        check_fetch(20);
    endtask

    task automatic test_random_valid();
        int n;
        for (int r = 0; r < 2; r++) begin
            n = $urandom_range(4, 80);
            for (int i = 0; i < n; i++) img[i] = 16'($urandom);
            load_image(n, 1'b1, 1'b1, 1'b1);
            check_fetch(25);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        i_Addressinstruction_Bus = 9'd0;
        pulse_start();
        n_cmp++;
        if ({o_Instr_Valid, o_Hold_Core, o_Load_Ready, o_Instruction} !== {3'b011, 16'h0000}) begin
            n_err++;
            $display("FAIL run_restart: got vld/hold/rdy=%b instr=%h need 011 0000",
                     {o_Instr_Valid, o_Hold_Core, o_Load_Ready}, o_Instruction);
        end
        n = $urandom_range(1, 40);
        for (int i = 0; i < n; i++) img[i] = 16'($urandom);
        load_image(n, 1'b0, 1'b1, 1'b0);
        check_fetch(20);
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        push_byte(8'h00, 1'b0, 1'b0);
        push_byte(8'h05, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            push_byte(8'h5A, 1'b0, 1'b0);
            push_byte(8'(i), 1'b0, 1'b0);
            model_mem[i] = {8'h5A, 8'(i)};
        end
        #2;
        i_Reset_n = 1'b0;
        #1;
        model_count = 0;
        n_cmp++;
        if ({o_Instruction, o_Instr_Valid, o_Hold_Core, o_Load_Ready, o_Load_Done, o_Load_Error}
                !== {16'h0000, 5'b01000}) begin
            n_err++;
            $display("FAIL async_reset: got instr=%h vld/hold/rdy/done/err=%b need 0000 01000",
                     o_Instruction, {o_Instr_Valid, o_Hold_Core, o_Load_Ready, o_Load_Done, o_Load_Error});
        end
        @(negedge i_Clk);
        i_Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_Addressinstruction_Bus = 9'(i);
            @(negedge i_Clk);
            n_cmp++;
            if (o_Instruction !== 16'h0000 || o_Instr_Valid !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset_fetch: got %h vld=%b need 0000 0", o_Instruction, o_Instr_Valid);
            end
        end
        img[0] = 16'hBEEF;
        load_image(1, 1'b1, 1'b0, 1'b0);
        fetch_one(9'd0);
        n_cmp++;
        if (o_Instruction !== 16'hBEEF) begin
            n_err++;
            $display("FAIL reload_beef: got %h need beef", o_Instruction);
        end
        fetch_one(9'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout need completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_Reset_n                = 1'b0;
        i_Addressinstruction_Bus = '0;
        i_Load_Start             = 1'b0;
        i_Load_Byte              = '0;
        i_Load_Valid             = 1'b0;
        repeat (3) @(negedge i_Clk);
        test_reset();
        test_basic();
        test_bad_length(16'h0000);
        test_bad_length(16'h0201);
        test_full();
        test_random_valid();
        test_back_to_back();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
